video_scanout: RTL



---
 rtl/video_pkg.sv | 36 +++
 rtl/video_timing.sv | 69 ++++++
 rtl/video_scanout.sv | 127 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the video scanout path.
// Framebuffer geometry, default raster timing and pipeline bundle.
package video_pkg;

  localparam int FB_W              = 128;
  localparam int FB_H              = 128;
  localparam int FB_BYTES_PER_LINE = 16;
  localparam int RAM_AW            = 11;
  localparam int RAM_DW            = 8;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Counter width needed to hold 0..total-1.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Stage-0 attributes of one raster position, carried down the
  // delay line so they meet the RAM byte fetched for that position.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       win;
    logic [2:0] bsel;
    logic       fs;
  } pix_ctl_t;

endpackage

// File: rtl/video_timing.sv
// Raster counters and stage-0 sync/active generation.
// Sync outputs are active-true; polarity is applied downstream.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HW       = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          active_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // Next raster position: vcnt advances only on hcnt wrap.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign hs_o     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
  assign vs_o     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
  assign active_o = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

endmodule

// File: rtl/video_scanout.sv
// Display-side reader of the video RAM: raster timing, sequential
// fetch addresses and 1bpp serialisation of the returned bytes.
module video_scanout
  import video_pkg::*;
#(
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   H_FP         = H_FP_DEF,
  parameter int   H_SYNC       = H_SYNC_DEF,
  parameter int   H_BP         = H_BP_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter int   V_FP         = V_FP_DEF,
  parameter int   V_SYNC       = V_SYNC_DEF,
  parameter int   V_BP         = V_BP_DEF,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   SCALE        = 2,
  parameter int   READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [RAM_AW-1:0] read_ad,
  input  logic [RAM_DW-1:0] read_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pixel,
  output logic              frame_start
);

  localparam int HW    = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int SH    = $clog2(SCALE);
  localparam int DEPTH = 1 + READ_LATENCY;

  localparam logic [HW-1:0] FBX = HW'(FB_W);
  localparam logic [VW-1:0] FBY = VW'(FB_H);

  logic [HW-1:0] hcnt, fb_x;
  logic [VW-1:0] vcnt, fb_y;
  logic          hs0, vs0, act0, in_win;
  pix_ctl_t      s0, tail;

  logic [RAM_AW-1:0] read_ad_q, read_ad_d;
  pix_ctl_t          pipe_q [DEPTH];

  logic hsync_q, vsync_q, de_q, pixel_q, fs_q;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .hs_o     (hs0),
    .vs_o     (vs0),
    .active_o (act0)
  );

  // Full-width compare so positions past the framebuffer never alias.
  assign fb_x   = hcnt >> SH;
  assign fb_y   = vcnt >> SH;
  assign in_win = act0 && (fb_x < FBX) && (fb_y < FBY);

  // Stage-0 bundle and the fetch address for this position.
  always_comb begin
    s0.hs     = hs0;
    s0.vs     = vs0;
    s0.act    = act0;
    s0.win    = in_win;
    s0.bsel   = fb_x[2:0];
    s0.fs     = (hcnt == '0) && (vcnt == '0);
    read_ad_d = read_ad_q;
    if (in_win) read_ad_d = {fb_y[6:0], fb_x[6:3]};
  end

  // Fetch address register; holds outside the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) read_ad_q <= '0;
    else       read_ad_q <= read_ad_d;
  end

  // Delay line matching the address register plus RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= s0;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[DEPTH-1];

  // Output register: joins delayed control with the returned byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      pixel_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= tail.hs ? SYNC_POL : ~SYNC_POL;
      vsync_q <= tail.vs ? SYNC_POL : ~SYNC_POL;
      de_q    <= tail.act;
      pixel_q <= tail.win & read_data[3'd7 - tail.bsel];
      fs_q    <= tail.fs;
    end
  end

  assign read_ad     = read_ad_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;

endmodule
